// File: rtl/alu_seq_exec.sv
// alu_seq_exec: sequential ALU executor.
// Single-cycle ops (add/sub/and/or/xor/nor/sll/srl) complete one cycle after
// they are accepted. The multi-cycle unsigned multiply (shift-add) and
// restoring divide are compiled in only when ALU_SEQ_MULDIV_EN is defined.
// Without that macro the mult/div codes decode as illegal, and hi, lo,
// div_zero and busy are tied to 0.
// WIDTH must be a power of two in the range 8..64.
module alu_seq_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic             div_zero
);

    localparam int SH = $clog2(WIDTH);

`ifdef ALU_SEQ_MULDIV_EN
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;
`else
    typedef enum logic [0:0] {IDLE, DONE} state_e;
`endif

    typedef enum logic [3:0] {
        K_ADD, K_SUB, K_AND, K_OR, K_XOR, K_NOR, K_SLL, K_SRL, K_MUL, K_DIV, K_ILL
    } kind_e;

    state_e state, state_nxt;
    kind_e  kind;
    logic   accept;
    logic   ill_r;

    // Maps alu_op/funct onto an operation class; alu_op overrides funct with add.
    function automatic kind_e decode(input logic force_add, input logic [5:0] f);
        kind_e k;
        k = K_ILL;
        if (force_add) begin
            k = K_ADD;
        end else begin
            case (f)
                6'b100000: k = K_ADD;
                6'b100010: k = K_SUB;
                6'b100100: k = K_AND;
                6'b100101: k = K_OR;
                6'b100110: k = K_XOR;
                6'b100111: k = K_NOR;
                6'b000000: k = K_SLL;
                6'b000010: k = K_SRL;
`ifdef ALU_SEQ_MULDIV_EN
                6'b011000: k = K_MUL;
                6'b011010: k = K_DIV;
`endif
                default:   k = K_ILL;
            endcase
        end
        return k;
    endfunction

    // Single-cycle result; add/sub wrap, shifts zero-fill and use b[SH-1:0].
    function automatic logic [WIDTH-1:0] alu_single(input kind_e k,
                                                     input logic [WIDTH-1:0] x,
                                                     input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] r;
        logic [SH-1:0]    sa;
        sa = y[SH-1:0];
        r  = '0;
        case (k)
            K_ADD:   r = x + y;
            K_SUB:   r = x - y;
            K_AND:   r = x & y;
            K_OR:    r = x | y;
            K_XOR:   r = x ^ y;
            K_NOR:   r = ~(x | y);
            K_SLL:   r = x << sa;
            K_SRL:   r = x >> sa;
            default: r = '0;
        endcase
        return r;
    endfunction

    assign kind   = decode(alu_op, funct);
    assign accept = (state == IDLE) && start;

`ifdef ALU_SEQ_MULDIV_EN
    // Iteration datapath: acc_hi/acc_lo hold the partial product
    // (or remainder/quotient), opd the latched multiplicand or divisor.
    logic [WIDTH-1:0] acc_hi, acc_lo, opd;
    logic [SH-1:0]    cnt;
    logic             last_iter;
    logic             b_zero;
    logic             dz_r;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_nxt, mul_lo_nxt;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem_nxt, div_quo_nxt;

    assign b_zero    = (b == '0);
    assign last_iter = (cnt == SH'(WIDTH - 1));

    // One shift-add multiply step and one restoring-divide step per cycle.
    always_comb begin
        mul_sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : '0);
        mul_hi_nxt  = mul_sum[WIDTH:1];
        mul_lo_nxt  = {mul_sum[0], acc_lo[WIDTH-1:1]};
        div_shift   = {acc_hi, acc_lo[WIDTH-1]};
        div_ge      = (div_shift >= {1'b0, opd});
        div_diff    = div_shift[WIDTH-1:0] - opd;
        div_rem_nxt = div_ge ? div_diff : div_shift[WIDTH-1:0];
        div_quo_nxt = {acc_lo[WIDTH-2:0], div_ge};
    end

    // Working registers: loaded at accept, stepped while iterating.
    always_ff @(posedge clk) begin
        if (accept) begin
            acc_hi <= '0;
            if (kind == K_MUL) begin
                acc_lo <= b;
                opd    <= a;
            end else begin
                acc_lo <= a;
                opd    <= b;
            end
        end else if (state == MUL) begin
            acc_hi <= mul_hi_nxt;
            acc_lo <= mul_lo_nxt;
        end else if (state == DIV) begin
            acc_hi <= div_rem_nxt;
            acc_lo <= div_quo_nxt;
        end
    end

    // Iteration counter, hi/lo results and divide-by-zero flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi   <= '0;
            lo   <= '0;
            dz_r <= 1'b0;
            cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt  <= '0;
                        dz_r <= (kind == K_DIV) && b_zero;
                        if ((kind == K_DIV) && b_zero) begin
                            lo <= '1;
                            hi <= a;
                        end
                    end
                end
                MUL: begin
                    cnt <= cnt + 1'b1;
                    if (last_iter) begin
                        hi <= mul_hi_nxt;
                        lo <= mul_lo_nxt;
                    end
                end
                DIV: begin
                    cnt <= cnt + 1'b1;
                    if (last_iter) begin
                        hi <= div_rem_nxt;
                        lo <= div_quo_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state == MUL) || (state == DIV);
    assign div_zero = done && dz_r;
`else
    assign hi       = '0;
    assign lo       = '0;
    assign busy     = 1'b0;
    assign div_zero = 1'b0;
`endif

    // State register; reset forces IDLE immediately and aborts any iteration.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    case (kind)
`ifdef ALU_SEQ_MULDIV_EN
                        K_MUL:   state_nxt = MUL;
                        K_DIV:   state_nxt = b_zero ? DONE : DIV;
`endif
                        default: state_nxt = DONE;
                    endcase
                end
            end
`ifdef ALU_SEQ_MULDIV_EN
            MUL, DIV: begin
                if (last_iter) state_nxt = DONE;
            end
`endif
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Single-cycle result and illegal flag, captured on the accepting edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result <= '0;
            ill_r  <= 1'b0;
        end else if (accept) begin
            ill_r <= (kind == K_ILL);
            if ((kind != K_ILL) && (kind != K_MUL) && (kind != K_DIV))
                result <= alu_single(kind, a, b);
        end
    end

    assign done    = (state == DONE);
    assign illegal = done && ill_r;

endmodule

// File: doc/alu_seq_exec.md
ALU_SEQ_EXEC -- requirements
Module: alu_seq_exec

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; SHALL be a power of two, 8..64.
REQ-002 Derived: SH = clog2(WIDTH), shift-amount width.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  request pulse; sampled only in IDLE.
REQ-006 alu_op  in  1  1 = force add regardless of funct; 0 = decode funct.
REQ-007 funct  in  6  function code.
REQ-008 a, b  in  WIDTH each  operands; shift amount = b[SH-1:0], shifted value = a.
REQ-009 result  out  WIDTH  registered result of single-cycle ops.
REQ-010 hi, lo  out  WIDTH each  registered mult/div results.
REQ-011 busy  out  1  high while in MUL or DIV.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 illegal  out  1  valid with done; 1 = undecoded funct.
REQ-014 div_zero  out  1  valid with done; 1 = divide by zero.

Function
REQ-015 Decode (alu_op=0): 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 100111 nor, 000000 sll, 000010 srl, 011000 mult, 011010 div; all other codes illegal.
REQ-016 FSM states IDLE, MUL, DIV, DONE; reset state IDLE.
REQ-017 IDLE + start + single-cycle op (or alu_op=1): result captured on accepting edge, -> DONE; done high for the following cycle.
REQ-018 IDLE + start + illegal funct: result unchanged, -> DONE with illegal=1.
REQ-019 IDLE + start + mult: operands latched, -> MUL; unsigned shift-add, one bit per cycle, WIDTH iterations; {hi,lo} = a*b (2*WIDTH bits); -> DONE.
REQ-020 IDLE + start + div, b!=0: -> DIV; unsigned restoring division, WIDTH iterations; lo = quotient, hi = remainder; -> DONE.
REQ-021 Div with b=0: no iteration; lo = all ones, hi = a, div_zero=1; -> DONE directly.
REQ-022 Latency from accepting edge to done: 1 cycle single-cycle/illegal/div-by-zero; WIDTH+1 cycles mult/div.
REQ-023 DONE -> IDLE unconditionally after one cycle; start during DONE, MUL or DIV SHALL be ignored (no queuing).
REQ-024 Operands and funct latched at accept; input changes while busy have no effect.
REQ-025 add/sub wrap modulo 2^WIDTH; no overflow flag.
REQ-026 sll/srl zero-fill; shift amount 0 returns a unchanged.
REQ-027 hi/lo change only on mult/div completion; result changes only on single-cycle op completion.
REQ-028 illegal and div_zero SHALL be 0 whenever done=0.

Reset
REQ-029 reset asserted: immediately IDLE; result, hi, lo, busy, done, illegal, div_zero, iteration counter = 0.
REQ-030 reset during MUL/DIV aborts; no done pulse; hi/lo read 0 after reset.
REQ-031 First start accepted on first rising edge with reset low.

Configuration
REQ-032 Macro ALU_SEQ_MULDIV_EN defined: mult/div per REQ-019..021.
REQ-033 Macro undefined: no MUL/DIV states or datapath; mult/div codes decode as illegal (REQ-018); hi, lo, div_zero tied 0; busy constant 0.

Verification (WIDTH=32, macro defined unless stated)
REQ-034 alu_op=1, funct=100010, a=5, b=3, start -> one cycle later done=1, result=8.
REQ-035 funct=100010, a=0, b=1 -> result=0xFFFFFFFF; funct=000000, a=1, b=31 -> result=0x80000000.
REQ-036 funct=011000, a=0xFFFFFFFF, b=2 -> busy 32 cycles, done at cycle 33, hi=1, lo=0xFFFFFFFE.
REQ-037 funct=011010, a=100, b=7 -> done at cycle 33, lo=14, hi=2; repeat b=0 -> done after 1 cycle, div_zero=1, lo=0xFFFFFFFF, hi=100.
REQ-038 Start mult, assert reset at cycle 10 -> no done; all outputs 0; new add accepted right after release.
REQ-039 Macro undefined: funct=011000 -> done after 1 cycle, illegal=1, busy never high.
